// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX register stage with load-use stall detect, flush/stall bubbles, hold, and a saturating bubble counter
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [6:0]       id_opcode,
  input  logic [2:0]       id_funct3,
  input  logic [6:0]       id_funct7,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic [4:0]       id_rd_addr,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [8:0]       id_ctrl,
  input  logic             flush,
  input  logic             ex_hold,
  output logic             load_use_stall,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [6:0]       ex_opcode,
  output logic [2:0]       ex_funct3,
  output logic [6:0]       ex_funct7,
  output logic [4:0]       ex_rs1_addr,
  output logic [4:0]       ex_rs2_addr,
  output logic [4:0]       ex_rd_addr,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [8:0]       ex_ctrl,
  output logic [CNT_W-1:0] bubble_cnt
);
  logic rs1_used, rs2_used, advance, bubble, count;
  always_comb begin
    rs1_used = !(id_opcode == 7'b0110111 || id_opcode == 7'b0010111 || id_opcode == 7'b1101111);
    rs2_used = id_opcode == 7'b0110011 || id_opcode == 7'b0100011 || id_opcode == 7'b1100011;
    load_use_stall = ex_valid && ex_ctrl[1] && ex_rd_addr != 5'd0 && id_valid && !flush &&
                     ((rs1_used && id_rs1_addr == ex_rd_addr) || (rs2_used && id_rs2_addr == ex_rd_addr));
    advance = flush || !ex_hold;
    bubble = flush || load_use_stall || !id_valid;
    count = flush || (!ex_hold && load_use_stall);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_opcode   <= '0;
      ex_funct3   <= '0;
      ex_funct7   <= '0;
      ex_rs1_addr <= '0;
      ex_rs2_addr <= '0;
      ex_rd_addr  <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_ctrl     <= '0;
      bubble_cnt  <= '0;
    end else begin
      if (advance) begin
        ex_valid   <= !bubble;
        ex_ctrl    <= bubble ? 9'd0 : id_ctrl;
        ex_rd_addr <= bubble ? 5'd0 : id_rd_addr;
        if (!bubble) begin
          ex_pc       <= id_pc;
          ex_opcode   <= id_opcode;
          ex_funct3   <= id_funct3;
          ex_funct7   <= id_funct7;
          ex_rs1_addr <= id_rs1_addr;
          ex_rs2_addr <= id_rs2_addr;
          ex_rs1_data <= id_rs1_data;
          ex_rs2_data <= id_rs2_data;
          ex_imm      <= id_imm;
        end
      end
      if (count && bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and table-driven checks of the ID/EX stage
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int CNT_W = 4;
  localparam logic [6:0] OP_R = 7'b0110011, OP_LD = 7'b0000011, OP_S = 7'b0100011, OP_B = 7'b1100011,
                         OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_I = 7'b0010011;
  localparam logic [8:0] C_ADD = 9'b100000100, C_LW = 9'b001011110, C_SW = 9'b001010001, C_ADDI = 9'b101000100;
  logic clk = 0, rst, id_valid, flush, ex_hold, load_use_stall, ex_valid;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [6:0] id_opcode, id_funct7, ex_opcode, ex_funct7;
  logic [2:0] id_funct3, ex_funct3;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr, ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [8:0] id_ctrl, ex_ctrl;
  logic [CNT_W-1:0] bubble_cnt;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_opcode(id_opcode),
    .id_funct3(id_funct3), .id_funct7(id_funct7), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rd_addr(id_rd_addr), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .flush(flush), .ex_hold(ex_hold), .load_use_stall(load_use_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .bubble_cnt(bubble_cnt)
  );
  typedef struct {
    string      name;
    logic [4:0] prod_rd;
    logic [8:0] prod_ctrl;
    logic       cons_valid;
    logic [6:0] cons_op;
    logic [4:0] cons_rs1;
    logic [4:0] cons_rs2;
    logic       exp_stall;
  } haz_t;
  haz_t vecs[13];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic [8:0] c, input logic [31:0] pc);
    id_valid = v; id_opcode = op; id_rs1_addr = r1; id_rs2_addr = r2; id_rd_addr = rd; id_ctrl = c;
    id_pc = pc; id_funct3 = pc[2:0] ^ 3'h5; id_funct7 = 7'h20;
    id_rs1_data = pc ^ 32'hAAAA0000; id_rs2_data = pc ^ 32'h00005555; id_imm = pc + 32'd4;
  endtask
  task automatic do_reset;
    rst = 1; tick; rst = 0;
  endtask
  initial begin
    vecs[0]  = '{"lui_rs1",    5'd5, C_LW,  1'b1, OP_LUI,   5'd5, 5'd0, 1'b0};
    vecs[1]  = '{"sw_rs2",     5'd5, C_LW,  1'b1, OP_S,     5'd1, 5'd5, 1'b1};
    vecs[2]  = '{"addi_rs2",   5'd5, C_LW,  1'b1, OP_I,     5'd1, 5'd5, 1'b0};
    vecs[3]  = '{"lw_x0",      5'd0, C_LW,  1'b1, OP_R,     5'd0, 5'd0, 1'b0};
    vecs[4]  = '{"r_rs1",      5'd5, C_LW,  1'b1, OP_R,     5'd5, 5'd1, 1'b1};
    vecs[5]  = '{"b_rs2",      5'd5, C_LW,  1'b1, OP_B,     5'd1, 5'd5, 1'b1};
    vecs[6]  = '{"auipc_rs1",  5'd5, C_LW,  1'b1, OP_AUIPC, 5'd5, 5'd5, 1'b0};
    vecs[7]  = '{"jal_rs1",    5'd5, C_LW,  1'b1, OP_JAL,   5'd5, 5'd5, 1'b0};
    vecs[8]  = '{"jalr_rs1",   5'd5, C_LW,  1'b1, OP_JALR,  5'd5, 5'd1, 1'b1};
    vecs[9]  = '{"load_rs1",   5'd5, C_LW,  1'b1, OP_LD,    5'd5, 5'd1, 1'b1};
    vecs[10] = '{"add_prod",   5'd5, C_ADD, 1'b1, OP_R,     5'd5, 5'd5, 1'b0};
    vecs[11] = '{"id_invalid", 5'd5, C_LW,  1'b0, OP_R,     5'd5, 5'd5, 1'b0};
    vecs[12] = '{"no_match",   5'd5, C_LW,  1'b1, OP_R,     5'd4, 5'd6, 1'b0};
    flush = 0; ex_hold = 0;
    drive(1, OP_R, 5'd1, 5'd2, 5'd3, C_ADD, 32'hFFFF_FFF0);
    rst = 1; tick; tick; rst = 0;
    check("rst_valid", ex_valid, 0);
    check("rst_pc", ex_pc, 0);
    check("rst_ctrl", ex_ctrl, 0);
    check("rst_rd", ex_rd_addr, 0);
    check("rst_data", {ex_rs1_data, ex_imm}, 0);
    check("rst_cnt", bubble_cnt, 0);
    check("rst_stall", load_use_stall, 0);
    drive(1, OP_R, 5'd1, 5'd2, 5'd3, C_ADD, 32'h100);
    tick;
    check("pt_valid", ex_valid, 1);
    check("pt_pc", ex_pc, 32'h100);
    check("pt_rd", ex_rd_addr, 3);
    check("pt_ctrl", ex_ctrl, C_ADD);
    check("pt_rs1_data", ex_rs1_data, 32'hAAAA0100);
    check("pt_imm", ex_imm, 32'h104);
    check("pt_stall", load_use_stall, 0);
    drive(1, OP_LD, 5'd1, 5'd0, 5'd5, C_LW, 32'h104);
    tick;
    check("lu_ex_ctrl", ex_ctrl, C_LW);
    drive(1, OP_R, 5'd5, 5'd1, 5'd6, C_ADD, 32'h108);
    #1 check("lu_stall", load_use_stall, 1);
    tick;
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_ctrl", ex_ctrl, 0);
    check("lu_bubble_rd", ex_rd_addr, 0);
    check("lu_cnt", bubble_cnt, 1);
    check("lu_stall_drop", load_use_stall, 0);
    tick;
    check("lu_capture_rd", ex_rd_addr, 6);
    check("lu_capture_pc", ex_pc, 32'h108);
    check("lu_cnt_keep", bubble_cnt, 1);
    drive(0, OP_R, 5'd1, 5'd2, 5'd7, C_ADD, 32'h10C);
    tick;
    check("inv_valid", ex_valid, 0);
    check("inv_ctrl", ex_ctrl, 0);
    check("inv_cnt", bubble_cnt, 1);
    for (int i = 0; i < 13; i++) begin
      do_reset;
      drive(1, (vecs[i].prod_ctrl[1] ? OP_LD : OP_R), 5'd1, 5'd2, vecs[i].prod_rd, vecs[i].prod_ctrl, 32'h200);
      tick;
      drive(vecs[i].cons_valid, vecs[i].cons_op, vecs[i].cons_rs1, vecs[i].cons_rs2, 5'd9, C_ADDI, 32'h204);
      #1 check({vecs[i].name, "_stall"}, load_use_stall, vecs[i].exp_stall);
      tick;
      check({vecs[i].name, "_next_valid"}, ex_valid, vecs[i].cons_valid & ~vecs[i].exp_stall);
      check({vecs[i].name, "_cnt"}, bubble_cnt, vecs[i].exp_stall);
    end
    do_reset;
    drive(1, OP_R, 5'd1, 5'd2, 5'd3, C_ADD, 32'h300);
    tick;
    flush = 1; ex_hold = 1;
    tick;
    flush = 0; ex_hold = 0;
    check("fh_valid", ex_valid, 0);
    check("fh_ctrl", ex_ctrl, 0);
    check("fh_cnt", bubble_cnt, 1);
    tick;
    check("fh_after_pc", ex_pc, 32'h300);
    ex_hold = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, OP_LD, 5'd4, 5'd4, 5'd8 + 5'(i), C_LW, 32'h400 + 32'(i * 4));
      tick;
      check("hold_pc", ex_pc, 32'h300);
      check("hold_rd", ex_rd_addr, 3);
      check("hold_ctrl", ex_ctrl, C_ADD);
      check("hold_cnt", bubble_cnt, 1);
    end
    ex_hold = 0;
    drive(1, OP_LD, 5'd1, 5'd0, 5'd5, C_LW, 32'h500);
    tick;
    ex_hold = 1;
    drive(1, OP_R, 5'd5, 5'd1, 5'd6, C_ADD, 32'h504);
    #1 check("hold_lu_stall", load_use_stall, 1);
    tick;
    check("hold_lu_ctrl", ex_ctrl, C_LW);
    check("hold_lu_cnt", bubble_cnt, 1);
    ex_hold = 0;
    flush = 1;
    #1 check("flush_lu_stall", load_use_stall, 0);
    tick;
    flush = 0;
    check("flush_lu_valid", ex_valid, 0);
    check("flush_lu_cnt", bubble_cnt, 2);
    drive(1, OP_LD, 5'd1, 5'd0, 5'd5, C_LW, 32'h600);
    tick;
    drive(1, OP_R, 5'd5, 5'd1, 5'd6, C_ADD, 32'h604);
    #1 check("rst_mid_pre", load_use_stall, 1);
    rst = 1; tick; rst = 0;
    #1 check("rst_mid_stall", load_use_stall, 0);
    check("rst_mid_cnt", bubble_cnt, 0);
    flush = 1;
    for (int i = 0; i < 14; i++) tick;
    check("sat_14", bubble_cnt, 14);
    for (int i = 0; i < 3; i++) tick;
    check("sat_17", bubble_cnt, 15);
    tick; tick;
    check("sat_hold", bubble_cnt, 15);
    flush = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline stage of the 5-stage RV32I core. Directly downstream of the opcode decoder: it registers the decoded control bits together with operands, immediate, PC and register addresses for the EX stage. Also detects load-use hazards, inserts bubbles for load-use and branch flush, and keeps a saturating bubble counter for performance checks.

Parameters:
XLEN, 32, datapath width
CNT_W, 32, width of bubble counter

Ports:
clk  in  1  core clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  PC of ID instruction
id_opcode  in  7  instr[6:0]
id_funct3  in  3  instr[14:12]
id_funct7  in  7  instr[31:25]
id_rs1_addr  in  5  source register 1
id_rs2_addr  in  5  source register 2
id_rd_addr  in  5  destination register
id_rs1_data  in  XLEN  register file read data 1
id_rs2_data  in  XLEN  register file read data 2
id_imm  in  XLEN  sign-extended immediate
id_ctrl  in  9  decoder bits {rd_src,branch_en,alu_in2_sel,pc_src,wb_sel,imm_sel,reg_w,mem_r,mem_w} (bit 8..0)
flush  in  1  EX resolved a taken branch/jump; ID instruction is wrong-path
ex_hold  in  1  EX/MEM cannot advance; freeze this stage
load_use_stall  out  1  combinational; freeze PC and IF/ID this cycle
ex_valid  out  1  registered valid
ex_pc, ex_opcode, ex_funct3, ex_funct7, ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_rs1_data, ex_rs2_data, ex_imm, ex_ctrl  out  (same widths as id_*)  registered copies
bubble_cnt  out  CNT_W  count of inserted bubbles

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset (rst=1 at posedge): every ex_* output and bubble_cnt go to 0. rst has priority over all other inputs.
- Latency: 1 cycle from ID inputs to ex_* outputs.
- rs1_used: id_opcode not in {0110111 LUI, 0010111 AUIPC, 1101111 JAL}.
- rs2_used: id_opcode in {0110011 R, 0100011 S, 1100011 B}.
- load_use_stall is asserted when all of the following hold:
  - ex_valid, ex_ctrl[1] (mem_r), ex_rd_addr != 0 and id_valid are all 1;
  - (rs1_used and id_rs1_addr == ex_rd_addr) or (rs2_used and id_rs2_addr == ex_rd_addr);
  - flush is 0.
- load_use_stall does not depend on ex_hold. Upstream ORs the two.
- Bubble: ex_valid=0, ex_ctrl=0, ex_rd_addr=0. All other data fields hold their previous value, and their content is don't-care.
- Posedge update, in priority order:
  1. rst: clear, as above.
  2. flush: load a bubble; bubble_cnt+1. Flush overrides ex_hold.
  3. ex_hold: all registers hold, including bubble_cnt.
  4. load_use_stall: load a bubble; bubble_cnt+1. The ID instruction is captured next cycle, because the bubble clears mem_r and stall drops.
  5. Otherwise capture all id_* fields. If id_valid=0, load a bubble and do not count it.
- bubble_cnt saturates at all-ones and never wraps.
- Wrong-path ID instruction during flush is discarded. No hazard is raised against it.
- A reset asserted mid-stall drops the stall on the next cycle, because ex_valid is 0 after reset.

Test Plan:
1. Reset: rst=1 for 2 cycles with all id_* nonzero and id_valid=1 -> all ex_* =0, bubble_cnt=0, load_use_stall=0.
2. Pass-through: ADD x3,x1,x2, id_pc=0x100, id_ctrl=9'b100000100 -> next cycle ex_valid=1, ex_pc=0x100, ex_rd_addr=3, ex_ctrl=9'b100000100, stall=0.
3. Load-use stall and release:
   - Cycle n: LW x5 captured (ex_ctrl=9'b001011110).
   - Cycle n+1: ID holds ADD x6,x5,x1 -> load_use_stall=1.
   - Cycle n+2: bubble, bubble_cnt=1, stall=0.
   - Cycle n+3: ADD captured, ex_rd_addr=6.
4. Hazard qualification after LW x5:
   - LUI with rs1 field=5 -> no stall.
   - LW x0, then ADD using x0 -> no stall.
   - SW with rs2=x5 -> stall=1.
   - ADDI with rs2 field=5 -> no stall.
5. Flush/hold:
   - flush=1 together with ex_hold=1 -> bubble next cycle, bubble_cnt+1.
   - ex_hold=1 for 3 cycles with changing id_* -> ex_* and bubble_cnt unchanged.
   - flush during a pending load-use -> stall=0 that cycle.
6. Saturation: CNT_W=4, 17 consecutive flushes -> bubble_cnt=4'hF and stays at 4'hF.
